// File: rtl/icb_sram_rsp_pkg.sv
// Shared ICB widths, bank base address and response record for the SRAM responder.
package icb_sram_rsp_pkg;

  localparam int unsigned ICB_AW = 32;
  localparam int unsigned ICB_DW = 32;
  localparam int unsigned ICB_MW = 4;

  localparam logic [ICB_AW-1:0] HWPE_SRAM_BASE = 32'h2000_0000;

  typedef struct packed {
    logic              err;
    logic [ICB_DW-1:0] rdata;
  } icb_rsp_t;

  localparam int unsigned RSP_W = $bits(icb_rsp_t);

  // Extra bit on the limit so a bank ending at 4 GiB does not wrap.
  function automatic logic addr_err(input logic [ICB_AW-1:0] addr,
                                    input logic [ICB_AW-1:0] base,
                                    input int unsigned       depth_log2);
    logic [ICB_AW:0] lim;
    lim = {1'b0, base} + ((ICB_AW+1)'(4) << depth_log2);
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= lim);
  endfunction

endpackage

// File: rtl/icb_rsp_fifo.sv
// Synchronous response FIFO; a push into a full FIFO is accepted only alongside a pop.
module icb_rsp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign full   = (32'(r_cnt) == DEPTH);
  assign empty  = (r_cnt == '0);
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = r_mem[r_rd_ptr];
  assign cnt    = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/icb_sram_rsp.sv
// ICB memory responder: word-addressed SRAM bank, one in-order response per command.
module icb_sram_rsp
  import icb_sram_rsp_pkg::*;
#(
  parameter logic [ICB_AW-1:0] ADDR_BASE  = HWPE_SRAM_BASE,
  parameter int unsigned       DEPTH_LOG2 = 10,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [ICB_AW-1:0] icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [ICB_DW-1:0] icb_cmd_wdata,
  input  logic [ICB_MW-1:0] icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [ICB_DW-1:0] icb_rsp_rdata,
  output logic              icb_rsp_err,
  output logic              busy
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH);

  logic                  w_cmd_hs;
  logic                  w_rsp_hs;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [ICB_DW-1:0]     w_rd_word;

  logic                  r_s1_valid;
  logic                  r_s1_err;
  logic                  r_s1_read;
  logic [ICB_DW-1:0]     r_s1_rdata;

  icb_rsp_t              w_s1_rsp;
  icb_rsp_t              w_head;
  icb_rsp_t              w_rsp;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CW-1:0]         w_fifo_cnt;
  logic                  w_s1_take;
  logic                  w_push;

  assign w_err    = addr_err(icb_cmd_addr, ADDR_BASE, DEPTH_LOG2);
  assign w_idx    = DEPTH_LOG2'((icb_cmd_addr - ADDR_BASE) >> 2);
  assign w_cmd_hs = icb_cmd_valid & icb_cmd_ready;

  // One byte-wide array per lane so each wmask bit maps to an independent write enable.
  for (genvar b = 0; b < ICB_MW; b++) begin : g_lane
    logic [7:0] r_mem [WORDS];
    always_ff @(posedge clk) begin
      if (w_cmd_hs && !icb_cmd_read && !w_err && icb_cmd_wmask[b])
        r_mem[w_idx] <= icb_cmd_wdata[8*b +: 8];
    end
    assign w_rd_word[8*b +: 8] = r_mem[w_idx];
  end

  assign icb_cmd_ready = (32'(w_fifo_cnt) + 32'(r_s1_valid)) < FIFO_DEPTH;

  always_comb begin
    w_s1_rsp = '0;
    if (r_s1_valid) begin
      w_s1_rsp.err = r_s1_err;
      if (r_s1_read && !r_s1_err) w_s1_rsp.rdata = r_s1_rdata;
    end
  end

  assign w_rsp         = w_fifo_empty ? w_s1_rsp : w_head;
  assign icb_rsp_valid = r_s1_valid | ~w_fifo_empty;
  assign icb_rsp_rdata = w_rsp.rdata;
  assign icb_rsp_err   = w_rsp.err;
  assign busy          = r_s1_valid | ~w_fifo_empty;
  assign w_rsp_hs      = icb_rsp_valid & icb_rsp_ready;

  // S1 either retires as head or moves into the FIFO; it only stalls when the FIFO is full.
  assign w_s1_take = r_s1_valid & w_fifo_empty & w_rsp_hs;
  assign w_push    = r_s1_valid & ~w_s1_take & (~w_fifo_full | w_rsp_hs);

  icb_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH - 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_rsp_hs & ~w_fifo_empty),
    .din   (w_s1_rsp),
    .dout  (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .cnt   (w_fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_read  <= 1'b0;
      r_s1_rdata <= '0;
    end else if (w_cmd_hs) begin
      r_s1_valid <= 1'b1;
      r_s1_err   <= w_err;
      r_s1_read  <= icb_cmd_read;
      if (icb_cmd_read && !w_err) r_s1_rdata <= w_rd_word;
    end else if (w_s1_take || w_push) begin
      r_s1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icb_sram_rsp.sv
// Bench for icb_sram_rsp: vector table, directed multi-cycle sequences and a randomized run
// scored against a word-array memory model with an in-order expected-response queue.
module tb_icb_sram_rsp;
  import icb_sram_rsp_pkg::*;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int unsigned DL2   = 10;
  localparam int unsigned WORDS = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        busy;

  always #5 clk = ~clk;

  icb_sram_rsp #(
    .ADDR_BASE  (BASE),
    .DEPTH_LOG2 (DL2),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .busy          (busy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mdl[int unsigned];
  logic [31:0] last_rdata;
  logic        last_err;
  int          rsp_seen = 0;
  bit          rand_rr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit mdl_err(input logic [31:0] a);
    longint unsigned la;
    la = 64'(a);
    return (a % 4 != 0) || (la < 64'(BASE)) || (la >= 64'(BASE) + 64'(4 * WORDS));
  endfunction

  task automatic mdl_apply(input bit rd, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
    int unsigned idx;
    logic [31:0] w;
    if (mdl_err(a)) begin
      exp_q.push_back({1'b1, 32'h0});
      return;
    end
    idx = (a - BASE) / 4;
    if (rd) begin
      exp_q.push_back({1'b0, mdl[idx]});
    end else begin
      w = mdl.exists(idx) ? mdl[idx] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (m[i]) w[8*i +: 8] = d[8*i +: 8];
      mdl[idx] = w;
      exp_q.push_back({1'b0, 32'h0});
    end
  endtask

  // Response scoreboard and hold-while-stalled checker.
  bit          prev_stall = 1'b0;
  logic [32:0] prev_rsp;
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("rsp_hold_valid", 32'(icb_rsp_valid), 32'd1);
        check("rsp_hold_rdata", icb_rsp_rdata, prev_rsp[31:0]);
        check("rsp_hold_err", 32'(icb_rsp_err), 32'(prev_rsp[32]));
      end
      if (icb_rsp_valid && icb_rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata=0x%08h err=%0d with none outstanding",
                   icb_rsp_rdata, icb_rsp_err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", icb_rsp_rdata, e[31:0]);
          check("rsp_err", 32'(icb_rsp_err), 32'(e[32]));
        end
        last_rdata = icb_rsp_rdata;
        last_err   = icb_rsp_err;
        rsp_seen++;
      end
      prev_stall = icb_rsp_valid && !icb_rsp_ready;
      prev_rsp   = {icb_rsp_err, icb_rsp_rdata};
    end
  end

  // Caller is aligned 1 time unit after a posedge; returns likewise.
  task automatic issue(input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output int waited);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = d;
    icb_cmd_wmask = m;
    waited = 0;
    forever begin
      @(negedge clk);
      if (icb_cmd_ready) break;
      waited++;
      if (waited > 64) begin
        n_checks++;
        n_fail++;
        $display("FAIL cmd_accept_timeout: addr 0x%08h never accepted, required accept", a);
        icb_cmd_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rand_rr) icb_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    mdl_apply(rd, a, d, m);
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    if (rand_rr) icb_rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic latency_probe(input bit rd, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_rd);
    icb_rsp_ready = 1'b1;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = d;
    icb_cmd_wmask = 4'hF;
    @(negedge clk);
    check("lat_pre_valid", 32'(icb_rsp_valid), 32'd0);
    check("lat_cmd_ready", 32'(icb_cmd_ready), 32'd1);
    mdl_apply(rd, a, d, 4'hF);
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    check("lat_rsp_valid", 32'(icb_rsp_valid), 32'd1);
    check("lat_rsp_rdata", icb_rsp_rdata, exp_rd);
    check("lat_rsp_err", 32'(icb_rsp_err), 32'd0);
    @(posedge clk); #1;
    check("lat_rsp_gone", 32'(icb_rsp_valid), 32'd0);
    check("lat_busy_gone", 32'(busy), 32'd0);
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vec[$];
    int          w;
    int          total_wait;
    int          seen0;
    int unsigned r;
    logic [31:0] a;
    bit          rd;
    logic [3:0]  m;

    vec.push_back('{1'b0, BASE + 32'h10,   32'hDEAD_BEEF, 4'hF, 32'h0,          1'b0});
    vec.push_back('{1'b1, BASE + 32'h10,   32'h0,         4'h0, 32'hDEAD_BEEF,  1'b0});
    vec.push_back('{1'b0, BASE + 32'h20,   32'hAABB_CCDD, 4'hF, 32'h0,          1'b0});
    vec.push_back('{1'b0, BASE + 32'h20,   32'h1122_3344, 4'h5, 32'h0,          1'b0});
    vec.push_back('{1'b1, BASE + 32'h20,   32'h0,         4'h0, 32'hAA22_CC44,  1'b0});
    vec.push_back('{1'b0, BASE,            32'hCAFE_F00D, 4'hF, 32'h0,          1'b0});
    vec.push_back('{1'b0, BASE + 32'h2,    32'h1234_5678, 4'hF, 32'h0,          1'b1});
    vec.push_back('{1'b0, BASE + 32'h1000, 32'h8765_4321, 4'hF, 32'h0,          1'b1});
    vec.push_back('{1'b1, BASE + 32'h1000, 32'h0,         4'h0, 32'h0,          1'b1});
    vec.push_back('{1'b1, BASE - 32'h4,    32'h0,         4'h0, 32'h0,          1'b1});
    vec.push_back('{1'b1, BASE,            32'h0,         4'h0, 32'hCAFE_F00D,  1'b0});
    vec.push_back('{1'b0, BASE + 32'h10,   32'h5A5A_5A5A, 4'h0, 32'h0,          1'b0});
    vec.push_back('{1'b1, BASE + 32'h10,   32'h0,         4'h0, 32'hDEAD_BEEF,  1'b0});
    vec.push_back('{1'b0, BASE + 32'hFFC,  32'h0102_0304, 4'hF, 32'h0,          1'b0});
    vec.push_back('{1'b1, BASE + 32'hFFC,  32'h0,         4'h0, 32'h0102_0304,  1'b0});

    rst = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = '0;
    icb_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
    check("rst_rsp_rdata", icb_rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(icb_rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single-cycle response latency for a write and the read that follows it.
    latency_probe(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0);
    latency_probe(1'b1, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF);

    foreach (vec[i]) begin
      issue(vec[i].rd, vec[i].addr, vec[i].wdata, vec[i].wmask, w);
      drain($sformatf("tbl%0d_drain", i));
      check($sformatf("tbl%0d_rdata", i), last_rdata, vec[i].exp_rdata);
      check($sformatf("tbl%0d_err", i), 32'(last_err), 32'(vec[i].exp_err));
    end

    // Backpressure: two reads fill stage+FIFO, the third waits for a response handshake.
    seen0 = rsp_seen;
    icb_rsp_ready = 1'b0;
    issue(1'b1, BASE + 32'h10, 32'h0, 4'h0, w);
    issue(1'b1, BASE + 32'h20, 32'h0, 4'h0, w);
    check("bp_second_wait", 32'(w), 32'd0);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = BASE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_cmd_ready_low", 32'(icb_cmd_ready), 32'd0);
      check("bp_head_rdata", icb_rsp_rdata, 32'hDEAD_BEEF);
      check("bp_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    icb_rsp_ready = 1'b1;
    issue(1'b1, BASE, 32'h0, 4'h0, w);
    check("bp_reopen_wait", 32'(w), 32'd1);
    drain("bp_drain");
    check("bp_rsp_count", 32'(rsp_seen - seen0), 32'd3);
    check("bp_last_rdata", last_rdata, 32'hCAFE_F00D);

    // Streaming writes at an 8-byte stride, one accepted per cycle.
    total_wait = 0;
    for (int k = 0; k < 16; k++) begin
      issue(1'b0, BASE + 32'(8 * k), 32'h0101_0101 * 32'(k + 1), 4'hF, w);
      total_wait += w;
    end
    check("stream_stalls", 32'(total_wait), 32'd0);
    check("stream_tail_valid", 32'(icb_rsp_valid), 32'd1);
    check("stream_tail_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("stream_busy_drop", 32'(busy), 32'd0);
    drain("stream_drain");
    issue(1'b1, BASE + 32'h38, 32'h0, 4'h0, w);
    drain("stream_rb_drain");
    check("stream_rb_rdata", last_rdata, 32'h0808_0808);

    // Reset with two responses pending drops them but keeps SRAM contents.
    icb_rsp_ready = 1'b0;
    issue(1'b0, BASE + 32'h300, 32'h600D_F00D, 4'hF, w);
    issue(1'b0, BASE + 32'h304, 32'h0BAD_CAFE, 4'hF, w);
    check("mrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("mrst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
    check("mrst_rsp_rdata", icb_rsp_rdata, 32'd0);
    rst = 1'b1;
    icb_rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, BASE + 32'h300, 32'h0, 4'h0, w);
    drain("mrst_rb0_drain");
    check("mrst_rb0_rdata", last_rdata, 32'h600D_F00D);
    issue(1'b1, BASE + 32'h304, 32'h0, 4'h0, w);
    drain("mrst_rb1_drain");
    check("mrst_rb1_rdata", last_rdata, 32'h0BAD_CAFE);

    // Randomized traffic with random response backpressure.
    rand_rr = 1'b1;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)
        a = BASE + 32'($urandom_range(0, WORDS - 1) * 4) + 32'($urandom_range(1, 3));
      else if (r == 1)
        a = ($urandom_range(0, 1) != 0) ? BASE - 32'(4 * $urandom_range(1, 16))
                                        : BASE + 32'h1000 + 32'(4 * $urandom_range(0, 16));
      else
        a = BASE + 32'h400 + 32'(4 * $urandom_range(0, 15));
      rd = ($urandom_range(0, 1) != 0);
      m  = 4'($urandom_range(0, 15));
      if (!mdl_err(a) && !mdl.exists((a - BASE) / 4)) begin
        rd = 1'b0;
        m  = 4'hF;
      end
      issue(rd, a, $urandom, m, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        icb_rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rand_rr = 1'b0;
    icb_rsp_ready = 1'b1;
    drain("rand_drain");
    @(posedge clk); #1;
    check("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
